// File: rtl/l0_skew_feeder_pkg.sv
// Shared defaults and derived widths for the west-edge skew feeder.
package l0_skew_feeder_pkg;
    localparam int ROW_DEF   = 8;
    localparam int BW_DEF    = 4;
    localparam int DEPTH_DEF = 64;

    function automatic int ptr_w(input int d);
        return $clog2(d);
    endfunction

    localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);
    localparam int CNT_W_DEF = PTR_W_DEF + 1;
endpackage

// File: rtl/l0_row_fifo.sv
// One lane of the feeder: storage indexed by the shared write pointer,
// private read pointer and occupancy, registered data/zero/valid outputs.
module l0_row_fifo
    import l0_skew_feeder_pkg::*;
#(
    parameter int bw    = BW_DEF,
    parameter int depth = DEPTH_DEF,
    localparam int PTR_W = ptr_w(depth),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr,
    input  logic [PTR_W-1:0] i_wptr,
    input  logic [bw-1:0]    i_wdata,
    input  logic             i_rd,
    output logic [CNT_W-1:0] o_cnt,
    output logic [bw-1:0]    o_data,
    output logic             o_zero,
    output logic             o_valid
);
    logic [bw-1:0]    r_mem [depth];
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic [bw-1:0]    r_data;
    logic             r_zero;
    logic             r_valid;
    logic [bw-1:0]    w_rdata;

    assign w_rdata = r_mem[r_rptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_wr) r_mem[i_wptr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_zero  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_rd;
            if (i_rd) begin
                r_data <= w_rdata;
                r_zero <= (w_rdata == '0);
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({i_wr, i_rd})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_cnt   = r_cnt;
    assign o_data  = r_data;
    assign o_zero  = r_zero;
    assign o_valid = r_valid;
endmodule

// File: rtl/l0_skew_feeder.sv
// West-edge feeder: row-vector writes, one read launch rippling down the
// rows one cycle per row to form the systolic diagonal wavefront.
module l0_skew_feeder
    import l0_skew_feeder_pkg::*;
#(
    parameter int row   = ROW_DEF,
    parameter int bw    = BW_DEF,
    parameter int depth = DEPTH_DEF,
    localparam int PTR_W = ptr_w(depth),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [row*bw-1:0] in,
    input  logic              rd,
    output logic              o_full,
    output logic              o_ready,
    output logic              o_empty,
    output logic              o_drained,
    output logic [row*bw-1:0] out,
    output logic [row-1:0]    out_zero,
    output logic [row-1:0]    out_valid
);
    logic [PTR_W-1:0]            r_wptr;
    logic [row-1:1]              r_sk;
    logic [row-1:0]              w_sk;
    logic                        w_wr;
    logic                        w_rd;
    logic [row-1:0][bw-1:0]      w_in;
    logic [row-1:0][bw-1:0]      w_data;
    logic [row-1:0][CNT_W-1:0]   w_cnt;

    assign w_in = in;

    // Last lane is read latest, so it bounds fullness; lane 0 bounds emptiness.
    assign o_full    = (w_cnt[row-1] == CNT_W'(depth));
    assign o_ready   = ~o_full;
    assign o_empty   = (w_cnt[0] == '0);
    assign w_wr      = wr & ~o_full;
    assign w_rd      = rd & ~o_empty;
    assign w_sk      = {r_sk, w_rd};
    assign o_drained = (w_cnt == '0) && (w_sk == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr <= '0;
            r_sk   <= '0;
        end else begin
            r_sk <= w_sk[row-2:0];
            if (w_wr) r_wptr <= r_wptr + PTR_W'(1);
        end
    end

    for (genvar g = 0; g < row; g++) begin : g_lane
        l0_row_fifo #(.bw(bw), .depth(depth)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_wr    (w_wr),
            .i_wptr  (r_wptr),
            .i_wdata (w_in[g]),
            .i_rd    (w_sk[g]),
            .o_cnt   (w_cnt[g]),
            .o_data  (w_data[g]),
            .o_zero  (out_zero[g]),
            .o_valid (out_valid[g])
        );
    end

    assign out = w_data;
endmodule

// File: tb/tb_l0_skew_feeder.sv
// Directed bench for l0_skew_feeder: skew timing, zero flags, full/drop,
// streaming at full and asynchronous reset mid-stream.
module tb_l0_skew_feeder;
    localparam int ROW = 8;
    localparam int BW  = 4;
    localparam int DEP = 64;

    logic              clk;
    logic              rst_n;
    logic              wr;
    logic [ROW*BW-1:0] din;
    logic              rd;
    logic              o_full, o_ready, o_empty, o_drained;
    logic [ROW*BW-1:0] dout;
    logic [ROW-1:0]    out_zero, out_valid;

    int n_chk;
    int n_err;
    int idx [ROW];

    l0_skew_feeder #(.row(ROW), .bw(BW), .depth(DEP)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .wr        (wr),
        .in        (din),
        .rd        (rd),
        .o_full    (o_full),
        .o_ready   (o_ready),
        .o_empty   (o_empty),
        .o_drained (o_drained),
        .out       (dout),
        .out_zero  (out_zero),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] fv(input int i, input int r);
        return BW'((i ^ (i >> 4)) + r);
    endfunction

    function automatic logic [ROW*BW-1:0] fw(input int i);
        logic [ROW*BW-1:0] w;
        for (int r = 0; r < ROW; r++) w[r*BW +: BW] = fv(i, r);
        return w;
    endfunction

    function automatic logic [BW-1:0] lane(input logic [ROW*BW-1:0] v, input int r);
        return v[r*BW +: BW];
    endfunction

    task automatic put(input logic [ROW*BW-1:0] d);
        wr = 1'b1;
        din = d;
        step();
        wr = 1'b0;
    endtask

    // Scoreboard: every valid lane must deliver fw() words in write order.
    task automatic mon();
        for (int r = 0; r < ROW; r++) begin
            if (out_valid[r]) begin
                chk($sformatf("data_l%0d_i%0d", r, idx[r]), 64'(lane(dout, r)), 64'(fv(idx[r], r)));
                idx[r]++;
            end
        end
    endtask

    initial begin
        logic [ROW-1:0] ev;
        logic [ROW-1:0] seen;
        int wseq;

        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        wr = 1'b0;
        rd = 1'b0;
        din = '0;
        for (int r = 0; r < ROW; r++) idx[r] = 0;

        // Reset and idle
        repeat (2) step();
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_out", 64'(dout), 64'(0));
        #2 rst_n = 1'b1;
        step();
        chk("idle_empty", 64'(o_empty), 64'(1));
        chk("idle_full", 64'(o_full), 64'(0));
        chk("idle_ready", 64'(o_ready), 64'(1));
        chk("idle_drained", 64'(o_drained), 64'(1));
        chk("idle_zero", 64'(out_zero), 64'(0));
        rd = 1'b1;
        step();
        rd = 1'b0;
        seen = '0;
        for (int c = 0; c < 9; c++) begin
            seen |= out_valid;
            step();
        end
        chk("idle_rd_valid", 64'(seen), 64'(0));
        chk("idle_rd_drained", 64'(o_drained), 64'(1));

        // Skew: lane r = r+1
        put(32'h87654321);
        chk("skew_notempty", 64'(o_empty), 64'(0));
        rd = 1'b1;
        step();
        rd = 1'b0;
        for (int k = 1; k <= ROW; k++) begin
            chk($sformatf("skew_valid_c%0d", k), 64'(out_valid), 64'(8'(1) << (k - 1)));
            chk($sformatf("skew_data_l%0d", k - 1), 64'(lane(dout, k - 1)), 64'(k));
            step();
        end
        chk("skew_valid_end", 64'(out_valid), 64'(0));
        chk("skew_zero", 64'(out_zero), 64'(0));
        chk("skew_drained", 64'(o_drained), 64'(1));

        // Zero flags: only lane 3 non-zero
        put(32'h0000A000);
        rd = 1'b1;
        step();
        rd = 1'b0;
        repeat (3) step();
        chk("zero_l3_valid", 64'(out_valid), 64'(8'b0000_1000));
        chk("zero_l3_flag", 64'(out_zero[3]), 64'(0));
        repeat (5) step();
        chk("zero_flags", 64'(out_zero), 64'(8'b1111_0111));
        chk("zero_l3_data", 64'(lane(dout, 3)), 64'(4'hA));
        chk("zero_l0_data", 64'(lane(dout, 0)), 64'(0));

        // Fill to depth, one extra write dropped, drain in order
        for (int i = 0; i < DEP; i++) begin
            if (i == DEP - 1) chk("fill_notfull", 64'(o_full), 64'(0));
            put(fw(i));
        end
        chk("fill_full", 64'(o_full), 64'(1));
        chk("fill_ready", 64'(o_ready), 64'(0));
        put(32'hFFFF_FFFF);
        chk("drop_full", 64'(o_full), 64'(1));
        for (int r = 0; r < ROW; r++) idx[r] = 0;
        for (int c = 0; c < 73; c++) begin
            rd = (c < DEP);
            step();
            for (int r = 0; r < ROW; r++) ev[r] = (c >= r) && (c <= r + DEP - 1);
            chk($sformatf("drain_valid_c%0d", c), 64'(out_valid), 64'(ev));
            mon();
            if (c >= 60) chk($sformatf("drain_drained_c%0d", c), 64'(o_drained), 64'(c >= 70));
        end
        rd = 1'b0;
        chk("drain_empty", 64'(o_empty), 64'(1));
        for (int r = 0; r < ROW; r++) chk($sformatf("drain_cnt_l%0d", r), 64'(idx[r]), 64'(DEP));

        // Streaming with wr and rd held while full
        for (int i = 0; i < DEP; i++) put(fw(i));
        chk("stream_start_full", 64'(o_full), 64'(1));
        for (int r = 0; r < ROW; r++) idx[r] = 0;
        wseq = DEP;
        for (int c = 0; c < 40; c++) begin
            wr = 1'b1;
            rd = 1'b1;
            if (c >= 8) begin
                din = fw(wseq);
                wseq++;
            end else begin
                din = 32'hFFFF_FFFF;
            end
            step();
            chk($sformatf("stream_full_c%0d", c), 64'(o_full), 64'(c < 7));
            mon();
        end
        wr = 1'b0;
        for (int c = 0; c < 80; c++) begin
            step();
            mon();
        end
        rd = 1'b0;
        step();
        for (int r = 0; r < ROW; r++) chk($sformatf("stream_cnt_l%0d", r), 64'(idx[r]), 64'(wseq));
        chk("stream_drained", 64'(o_drained), 64'(1));

        // Asynchronous reset two cycles after a launch
        for (int i = 0; i < 10; i++) put(32'h5A5A_5A5A);
        rd = 1'b1;
        step();
        rd = 1'b0;
        step();
        chk("ar_pre_valid", 64'(out_valid), 64'(8'b0000_0010));
        chk("ar_pre_drained", 64'(o_drained), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'(0));
        chk("ar_out", 64'(dout), 64'(0));
        chk("ar_zero", 64'(out_zero), 64'(0));
        chk("ar_drained", 64'(o_drained), 64'(1));
        chk("ar_empty", 64'(o_empty), 64'(1));
        step();
        step();
        #2 rst_n = 1'b1;
        step();
        chk("ar_post_empty", 64'(o_empty), 64'(1));
        chk("ar_post_ready", 64'(o_ready), 64'(1));
        rd = 1'b1;
        step();
        rd = 1'b0;
        seen = '0;
        for (int c = 0; c < 9; c++) begin
            seen |= out_valid;
            step();
        end
        chk("ar_post_rd_valid", 64'(seen), 64'(0));
        chk("ar_post_out", 64'(dout), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/l0_skew_feeder.md
Name: l0_skew_feeder

Overview:
- West-edge activation/weight feeder for the mac_tile systolic array.
- Holds one FIFO per array row, all written together as one row-vector word.
- Reads are launched once and ripple down the rows with a one-cycle-per-row skew, producing the diagonal wavefront the array expects.
- Also drives the per-row zero flags used for the tiles' clock gating, so the array sits directly downstream of this block.

Parameters:
- row, 8, number of array rows (FIFO lanes)
- bw, 4, bits per element (matches mac_tile bw)
- depth, 64, entries per row FIFO; power of two, at least 2

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- wr  input  1  write request; writes one row-vector word
- in  input  row*bw  write data; lane r = in[r*bw +: bw]
- rd  input  1  read launch for row 0; rows 1..row-1 follow automatically
- o_full  output  1  no write can be accepted this cycle
- o_ready  output  1  equals ~o_full
- o_empty  output  1  row-0 FIFO holds no entries (a new rd will be dropped)
- o_drained  output  1  every row FIFO is empty and no skewed read is in flight
- out  output  row*bw  skewed read data; lane r feeds in_w of array row r
- out_zero  output  row  lane r data is all-zero (drives in_w_zero)
- out_valid  output  row  lane r holds a freshly read word this cycle

Behaviour:
Reset (reset low, asynchronous):
- Write pointer, all read pointers and all occupancy counts cleared.
- Skew shift register cleared; any in-flight reads are cancelled.
- out=0, out_zero=0, out_valid=0, o_full=0, o_ready=1, o_empty=1, o_drained=1.
- FIFO storage contents are not cleared.

Write path:
- One shared write pointer for all lanes; each lane keeps its own occupancy count.
- A write is accepted when wr=1 and o_full=0; all lanes store their slice at the write pointer.
- The write pointer wraps modulo depth.
- wr while o_full=1 is dropped silently; no state changes.

Read launch and skew:
- Effective launch: rd_eff = rd & ~o_empty. rd while empty is dropped and never propagates down the rows.
- Skew register sk[row-1:0]: sk[0]=rd_eff, and sk[r] takes sk[r-1] from the previous cycle.
- Lane r is read in the cycle where sk[r]=1, i.e. r cycles after launch.
- The lane read pointer advances and its occupancy decrements on that edge.

Read data and latency:
- out, out_zero and out_valid are registered.
- Lane r data appears r+1 cycles after the rd edge.
- out_zero[r] = (stored word == 0), registered with the data.
- In a cycle with no read, lane r holds its last out and out_zero, and out_valid[r]=0.

Full and empty:
- Lane row-1 is always the most occupied lane.
- o_full = (occupancy[row-1] == depth).
- o_empty = (occupancy[0] == 0).
- o_drained = all occupancies 0 and sk == 0.

Simultaneous write and read on a lane:
- Occupancy is unchanged.
- A write while o_full=1 is still dropped, even if a lane read frees a slot in the same cycle. Full is evaluated before the read.
- Read-during-write to the same address cannot occur, because a read only happens on a non-empty lane.

Back-to-back reads:
- rd may be held high every cycle; each lane then streams one word per cycle.
- Occupancy arithmetic uses log2(depth)+1 bits, with no overflow.

Decomposition:
- Shared package: default parameters (row=8, bw=4, depth=64) and the derived pointer width (log2 depth) and count width (log2 depth + 1).
- Natural sub-module: l0_row_fifo, a single-lane FIFO with an external shared write pointer, its own read pointer, occupancy count and registered out/zero/valid.
- This top instantiates row copies plus the write pointer, full/empty logic and skew register.

Test Plan:
- Reset then idle: after reset high, o_empty=1, o_full=0, o_drained=1, out_valid=0; rd pulse → no out_valid on any lane and no pointer movement.
- Skew, row=8: write word with lane r = r+1 (lane0=1 … lane7=8), pulse rd one cycle → out_valid[r] high exactly at cycle r+1 after rd; out lane r = r+1; out_zero all 0.
- Zero flags: write in = all zeros except lane3 = 4'hA, then rd → out_zero = 8'b11110111 on the respective skewed cycles; lane3 out = 4'hA.
- Full, depth=64: 64 writes → o_full=1, o_ready=0; a 65th write is dropped; then 64 rds → read values match write order; o_drained=1 exactly 8 cycles after the last rd.
- Streaming at full: hold wr and rd high together with the FIFO full → wr dropped while o_full; after the row-7 read frees a slot, writes resume; total count written equals total count read with no loss or duplication.
- Async reset mid-stream: assert reset two cycles after rd with 10 entries queued → outputs, out_valid and sk clear immediately without a clock edge; after release, o_empty=1 and the old data is not readable.
